// File: rtl/hit_manager_pkg.sv
// Shared definitions for the hit manager: game state encoding, collision vector
// width and the bit index of each collision type.
package hit_manager_pkg;

  localparam int unsigned COLLISION_W = 10;

  // Bit positions inside the collision vector
  localparam int unsigned COL_PLAYER_MMISSILE  = 0;
  localparam int unsigned COL_PLAYER_MONSTER   = 1;
  localparam int unsigned COL_MONSTER_PMISSILE = 2;
  localparam int unsigned COL_MONSTER_SHIELD   = 3;
  localparam int unsigned COL_SHIELD_PMISSILE  = 4;
  localparam int unsigned COL_SHIELD_MMISSILE  = 5;
  localparam int unsigned COL_BORDER_PLAYER    = 6;
  localparam int unsigned COL_BORDER_MONSTER   = 7;
  localparam int unsigned COL_BORDER_PMISSILE  = 8;
  localparam int unsigned COL_BORDER_MMISSILE  = 9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2
  } game_state_t;

endpackage

// File: rtl/collision_frame_latch.sv
// Sticky per-frame collision accumulator.
// Ports:
//   clk          system clock
//   resetN       synchronous active-low reset
//   startOfFrame one-cycle frame boundary pulse
//   collision    per-pixel collision vector
//   hitPulse     one-cycle summary of the frame that just ended
module collision_frame_latch
  import hit_manager_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic [COLLISION_W-1:0] collision,
  output logic [COLLISION_W-1:0] hitPulse
);

  logic [COLLISION_W-1:0] latch_q, latch_d;
  logic [COLLISION_W-1:0] pulse_q, pulse_d;

  // A collision in the boundary cycle belongs to the frame that is ending.
  always_comb begin
    if (startOfFrame) begin
      pulse_d = latch_q | collision;
      latch_d = '0;
    end else begin
      pulse_d = '0;
      latch_d = latch_q | collision;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      latch_q <= '0;
      pulse_q <= '0;
    end else begin
      latch_q <= latch_d;
      pulse_q <= pulse_d;
    end
  end

  assign hitPulse = pulse_q;

endmodule

// File: rtl/hit_manager.sv
// Frame-synchronous collision consumer: turns per-frame hit pulses into lives,
// score, an invulnerability window and the IDLE/PLAY/GAME_OVER state.
// Ports:
//   clk, resetN   clock and synchronous active-low reset
//   startOfFrame  one-cycle frame boundary pulse
//   collision     collision vector from the detector
//   startGame     one-cycle start request
//   hitPulse      per-type hit pulses for the frame just ended
//   lives, score  player status
//   invulnerable  high while the post-hit window runs
//   gameState     0 IDLE, 1 PLAY, 2 GAME_OVER
//   gameOver      one-cycle pulse on entry to GAME_OVER
module hit_manager
  import hit_manager_pkg::*;
#(
  parameter int unsigned NUM_LIVES         = 3,
  parameter int unsigned SCORE_PER_MONSTER = 10,
  parameter int unsigned SCORE_W           = 14,
  parameter int unsigned INVULN_FRAMES     = 60
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic [COLLISION_W-1:0] collision,
  input  logic                   startGame,
  output logic [COLLISION_W-1:0] hitPulse,
  output logic [2:0]             lives,
  output logic [SCORE_W-1:0]     score,
  output logic                   invulnerable,
  output logic [1:0]             gameState,
  output logic                   gameOver
);

  localparam logic [SCORE_W-1:0] ScoreMax   = '1;
  localparam logic [2:0]         LivesInit  = 3'(NUM_LIVES);
  localparam logic [7:0]         InvulnInit = 8'(INVULN_FRAMES);

  logic [COLLISION_W-1:0] hit_pulse;
  logic                   sof_q;
  game_state_t            state_q, state_d;
  logic [2:0]             lives_q, lives_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [7:0]             inv_cnt_q, inv_cnt_d;
  logic                   game_over_q, game_over_d;
  logic [31:0]            score_sum;
  logic [SCORE_W-1:0]     score_sat;
  logic                   player_hit;
  logic                   fatal;

  collision_frame_latch u_latch (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .collision    (collision),
    .hitPulse     (hit_pulse)
  );

  assign score_sum  = 32'(score_q) + 32'(SCORE_PER_MONSTER);
  assign score_sat  = (score_sum > 32'(ScoreMax)) ? ScoreMax : score_sum[SCORE_W-1:0];
  assign player_hit = hit_pulse[COL_PLAYER_MMISSILE] | hit_pulse[COL_PLAYER_MONSTER];

  // sof_q marks the processing cycle (hitPulse valid). The window ticks on that
  // same edge, so a frame's hits are judged against the window as it stood when
  // the frame ended: a load of N blocks hits from the next N frames.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    inv_cnt_d   = inv_cnt_q;
    game_over_d = 1'b0;
    fatal       = 1'b0;
    unique case (state_q)
      IDLE, GAME_OVER: begin
        if (startGame) begin
          lives_d   = LivesInit;
          score_d   = '0;
          inv_cnt_d = '0;
          state_d   = PLAY;
        end
      end
      PLAY: begin
        if (sof_q) begin
          if (inv_cnt_q != 8'd0) begin
            inv_cnt_d = inv_cnt_q - 8'd1;
          end
          if (hit_pulse[COL_MONSTER_PMISSILE]) begin
            score_d = score_sat;
          end
          if (player_hit && (inv_cnt_q == 8'd0)) begin
            lives_d   = lives_q - 3'd1;
            inv_cnt_d = InvulnInit;
            fatal     = (lives_q == 3'd1);
          end
          // A monster reaching the player ends the game regardless of the window.
          if (fatal || hit_pulse[COL_PLAYER_MONSTER]) begin
            state_d     = GAME_OVER;
            game_over_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      sof_q       <= 1'b0;
      state_q     <= IDLE;
      lives_q     <= '0;
      score_q     <= '0;
      inv_cnt_q   <= '0;
      game_over_q <= 1'b0;
    end else begin
      sof_q       <= startOfFrame;
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      inv_cnt_q   <= inv_cnt_d;
      game_over_q <= game_over_d;
    end
  end

  assign hitPulse     = hit_pulse;
  assign lives        = lives_q;
  assign score        = score_q;
  assign invulnerable = (inv_cnt_q != 8'd0);
  assign gameState    = state_q;
  assign gameOver     = game_over_q;

endmodule

// File: tb/tb_hit_manager.sv
// Scoreboard bench for hit_manager (SCORE_W=5 so saturation is reachable).
module tb_hit_manager;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic [9:0] collision = '0;
  logic       startGame = 1'b0;
  logic [9:0] hitPulse;
  logic [2:0] lives;
  logic [4:0] score;
  logic       invulnerable;
  logic [1:0] gameState;
  logic       gameOver;

  hit_manager #(
    .NUM_LIVES         (3),
    .SCORE_PER_MONSTER (10),
    .SCORE_W           (5),
    .INVULN_FRAMES     (60)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .collision    (collision),
    .startGame    (startGame),
    .hitPulse     (hitPulse),
    .lives        (lives),
    .score        (score),
    .invulnerable (invulnerable),
    .gameState    (gameState),
    .gameOver     (gameOver)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lives;
    int score;
    int inv;
    int st;
    int go;
  } st_exp_t;

  logic [9:0] pulse_q[$];
  st_exp_t    state_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  bit         mon_en = 0;
  bit         sof_d1, sof_d2, sg_d1, rst_d1;

  always @(posedge clk) begin
    sof_d1 <= startOfFrame;
    sof_d2 <= sof_d1;
    sg_d1  <= startGame;
    rst_d1 <= !resetN;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Monitor: hitPulse is presented the cycle after a frame edge, status the cycle after that
  // (or the cycle after a start request / reset).
  always @(negedge clk) begin
    st_exp_t e;
    if (sof_d1) begin
      if (pulse_q.size() == 0) check("pulse_q_underflow", 1, 0);
      else check("hitPulse", int'(hitPulse), int'(pulse_q.pop_front()));
    end else if (mon_en) begin
      check("hitPulse_idle", int'(hitPulse), 0);
    end
    if (sof_d2 || sg_d1 || rst_d1) begin
      if (state_q.size() == 0) begin
        check("state_q_underflow", 1, 0);
      end else begin
        e = state_q.pop_front();
        check("lives", int'(lives), e.lives);
        check("score", int'(score), e.score);
        check("invulnerable", int'(invulnerable), e.inv);
        check("gameState", int'(gameState), e.st);
        check("gameOver", int'(gameOver), e.go);
      end
    end else if (mon_en) begin
      check("gameOver_idle", int'(gameOver), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_state(input int l, input int s, input int i, input int st, input int go);
    st_exp_t e;
    e.lives = l; e.score = s; e.inv = i; e.st = st; e.go = go;
    state_q.push_back(e);
  endtask

  task automatic do_reset();
    push_state(0, 0, 0, 0, 0);
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
  endtask

  task automatic start_game(input int l, input int s, input int i, input int st);
    push_state(l, s, i, st, 0);
    startGame = 1'b1;
    tick();
    startGame = 1'b0;
    tick();
    tick();
  endtask

  // Ten body cycles (body pulsed on odd cycles, reps times), then the frame edge
  // carrying sof_col, then quiet cycles while the monitor catches up.
  task automatic frame(input logic [9:0] body, input int reps, input logic [9:0] sof_col,
                       input logic [9:0] e_hp, input int e_l, input int e_s, input int e_i,
                       input int e_st, input int e_go);
    for (int i = 0; i < 10; i++) begin
      collision = ((i % 2 == 1) && (i / 2 < reps)) ? body : 10'h000;
      tick();
    end
    startOfFrame = 1'b1;
    collision    = sof_col;
    pulse_q.push_back(e_hp);
    push_state(e_l, e_s, e_i, e_st, e_go);
    tick();
    startOfFrame = 1'b0;
    collision    = '0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    mon_en = 1;
    // Idle frames: pulses still generated, status untouched
    frame(10'h000, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0);
    frame(10'h004, 1, 10'h000, 10'h004, 0, 0, 0, 0, 0);
    start_game(3, 0, 0, 1);
    // Five monster hits in one frame count once
    frame(10'h004, 5, 10'h000, 10'h004, 3, 10, 0, 1, 0);
    // Player hit, then 60 frames of blocked hits
    frame(10'h001, 1, 10'h000, 10'h001, 2, 10, 1, 1, 0);
    for (int n = 2; n <= 61; n++) begin
      frame(10'h001, 1, 10'h000, 10'h001, 2, 10, (n < 61) ? 1 : 0, 1, 0);
    end
    frame(10'h001, 1, 10'h000, 10'h001, 1, 10, 1, 1, 0);
    // Let the window expire, then the last life goes
    for (int n = 63; n <= 122; n++) begin
      frame(10'h000, 0, 10'h000, 10'h000, 1, 10, (n < 122) ? 1 : 0, 1, 0);
    end
    frame(10'h001, 1, 10'h000, 10'h001, 0, 10, 1, 2, 1);
    // Frozen in GAME_OVER
    frame(10'h004, 1, 10'h000, 10'h004, 0, 10, 1, 2, 0);
    start_game(3, 0, 0, 1);
    frame(10'h001, 1, 10'h000, 10'h001, 2, 0, 1, 1, 0);
    // Monster contact while invulnerable is fatal, lives unchanged
    frame(10'h002, 1, 10'h000, 10'h002, 2, 0, 1, 2, 1);
    // Collision on the boundary cycle belongs to the ending frame only
    frame(10'h000, 0, 10'h010, 10'h010, 2, 0, 1, 2, 0);
    frame(10'h000, 0, 10'h000, 10'h000, 2, 0, 1, 2, 0);
    start_game(3, 0, 0, 1);
    // Saturation at 31
    frame(10'h004, 1, 10'h000, 10'h004, 3, 10, 0, 1, 0);
    frame(10'h004, 1, 10'h000, 10'h004, 3, 20, 0, 1, 0);
    frame(10'h004, 1, 10'h000, 10'h004, 3, 30, 0, 1, 0);
    frame(10'h004, 1, 10'h000, 10'h004, 3, 31, 0, 1, 0);
    frame(10'h004, 1, 10'h000, 10'h004, 3, 31, 0, 1, 0);
    // Mid-frame reset with a loaded latch
    collision = 10'h008;
    tick();
    tick();
    collision = '0;
    do_reset();
    frame(10'h000, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("pulse_q_drained", pulse_q.size(), 0);
    check("state_q_drained", state_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_manager.md
# hit_manager

Frame-synchronous collision consumer. It sits directly downstream of the pixel-level collision detector and accumulates the 10-bit collision vector over each video frame. At every frame start it emits one-cycle per-type hit pulses and, from those, maintains player lives, score, a post-hit invulnerability window and the game-state FSM (IDLE / PLAY / GAME_OVER) used by the object and display blocks.

## Interface
- NUM_LIVES, 3: lives loaded on game start (1..7).
- SCORE_PER_MONSTER, 10: points added per frame with a monster/player-missile hit.
- SCORE_W, 14: score width; score saturates at 2^SCORE_W-1.
- INVULN_FRAMES, 60: frames during which further player hits are ignored after a hit (1..255).
- clk  in  1  system clock. One clock domain; no clock enables.
- resetN  in  1  reset, synchronous, active-low.
- startOfFrame  in  1  one-cycle pulse per frame.
- collision  in  10  per-pixel collision vector from the collision detector. Bit map: 0 player/monMissile, 1 player/monster, 2 monster/plMissile, 3 monster/shield, 4 shield/plMissile, 5 shield/monMissile, 6 border/player, 7 border/monster, 8 border/plMissile, 9 border/monMissile.
- startGame  in  1  one-cycle start request from the key debouncer.
- hitPulse  out  10  one-cycle pulse per type seen during the frame just ended.
- lives  out  3  remaining lives.
- score  out  SCORE_W  current score.
- invulnerable  out  1  high while the invulnerability window runs.
- gameState  out  2  0 IDLE, 1 PLAY, 2 GAME_OVER.
- gameOver  out  1  one-cycle pulse on entry to GAME_OVER.

## Operation
- Frame latch: sticky OR of collision into a 10-bit register.
  - On a cycle with startOfFrame=1, hitPulse is loaded with latch|collision and the latch is cleared to 0.
  - A collision present in the startOfFrame cycle counts toward the ending frame only.
  - On other cycles, hitPulse=0.
- FSM behaviour:
  - IDLE: hitPulse is still generated. lives, score and invuln are unchanged. On startGame, load lives=NUM_LIVES, clear score and the invulnerability counter, then go to PLAY.
  - PLAY, on the cycle after hitPulse:
    - Player hit = hitPulse[0] | hitPulse[1].
    - If a player hit occurs and the invulnerability counter is 0, lives decrements and the counter is loaded with INVULN_FRAMES.
    - If that hit takes lives to 0, or hitPulse[1] occurs at all, go to GAME_OVER and pulse gameOver. A monster reaching the player is fatal even while invulnerable.
    - If hitPulse[2] is set, add SCORE_PER_MONSTER to score, saturating. Score updates in the same cycle as a life loss.
  - The invulnerability counter decrements by 1 at each startOfFrame while nonzero. invulnerable = (counter != 0).
  - GAME_OVER: lives, score and invuln are frozen. On startGame, behave as IDLE's start (reload and go to PLAY).
  - startGame in PLAY is ignored.
- Reset: latch=0, hitPulse=0, lives=0, score=0, counter=0, invulnerable=0, gameState=IDLE, gameOver=0.
  - Reset mid-frame discards the accumulated latch.

## Timing
- Collision at any cycle of frame N → hitPulse on the cycle after frame N+1's startOfFrame edge (1-cycle registered latency from that edge).
- lives, score, gameState and gameOver update 1 cycle after hitPulse, i.e. 2 cycles after the startOfFrame edge.
- startGame acts at the next clock edge; gameState reads PLAY 1 cycle later.
- Simultaneous startGame and hitPulse in IDLE or GAME_OVER: the start wins and the hits are not applied.
- Simultaneous startOfFrame and hit-processing cycles cannot overlap, because processing always falls 1 cycle after the pulse.
- Back-to-back startOfFrame cycles (a test case, not a real condition): each one produces its own hitPulse.
- Invulnerability counter:
  - It is loaded at the processing edge and first decrements at the next startOfFrame.
  - INVULN_FRAMES=60 therefore blocks hits detected in the following 60 frames.

## Structure
- Package hit_manager_pkg contains:
  - the game_state_t enum (IDLE, PLAY, GAME_OVER);
  - the collision index localparams (COL_PLAYER_MMISSILE=0 … COL_BORDER_MMISSILE=9);
  - the width constant COLLISION_W=10.
- Sub-module collision_frame_latch holds the sticky latch and hitPulse generation (ports clk, resetN, startOfFrame, collision, hitPulse).
- hit_manager instantiates collision_frame_latch and holds the FSM, lives, score and invulnerability logic.

## Test plan
- Reset then idle frames: collision=0x004 during frame 1 → hitPulse=0x004 for exactly 1 cycle after the frame-2 startOfFrame; score stays 0 (IDLE); all outputs 0 after reset.
- startGame, then collision[2] pulses 5 times in one frame → one hitPulse[2]; score=10, not 50.
- In PLAY, collision[0] in frame 1 → lives 3→2 and invulnerable=1. collision[0] again in frames 2..61 → lives stays 2. collision[0] in frame 62 → lives=1.
- lives=1 and collision[0] → lives=0, gameState=GAME_OVER, one gameOver pulse. Further collision[2] → score unchanged. startGame → lives=3, score=0, PLAY.
- Invulnerable and collision[1] → immediate GAME_OVER while lives stay unchanged. Collision asserted exactly on the startOfFrame cycle → appears in that cycle's hitPulse; next frame's hitPulse=0.
- SCORE_W=5 with score preset to 30 via repeated hits → score saturates at 31. Then assert resetN=0 for 1 cycle mid-frame with the latch nonzero → all outputs and state cleared and the next hitPulse=0.
